fp_int_cevirici: RTL and testbench
==================================

Name: fp_int_cevirici

Overview:
- Parametrised successor of the single-precision float-to-integer converter.
- Converts one IEEE-754 binary32 operand to a signed or unsigned OUT_W-bit integer.
- Rounding mode is selectable at runtime; out-of-range results saturate; results carry exception flags.
- Sits between the FP datapath and integer consumers, using valid/ready handshakes on both sides, with one operation in flight.

Parameters:
- OUT_W, 32, output integer width; legal range 8..32.
- SIGNED_OUT, 1, 1 = two's-complement output; 0 = unsigned output.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- en_i  in  1  clock enable; when low, all state holds (stall, not clear)
- valid_i  in  1  operand valid
- ready_o  out  1  converter can accept an operand
- g1_i  in  32  binary32 operand
- rnd_i  in  2  rounding mode, sampled with g1_i: 00 toward zero, 01 nearest-even, 10 floor, 11 ceil
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- c_o  out  OUT_W  integer result
- inv_o  out  1  invalid: NaN, ±Inf, or out-of-range (saturated)
- nx_o  out  1  inexact: nonzero fraction discarded and result not saturated

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - rst_i is synchronous and active-high, and has priority over en_i.
  - Reset puts the FSM in IDLE and clears ready_o=1, valid_o=0, c_o=0, inv_o=0, nx_o=0 and all internal registers.
  - Reset mid-operation drops the operation; no result is emitted.
- FSM, advancing only when en_i=1:
  - IDLE: ready_o=1. On valid_i&&ready_o, capture g1_i and rnd_i, then go to UNPACK.
  - UNPACK: split sign, exponent and mantissa. Mantissa gets the hidden 1 prepended; it is 0 for zero/denormal. Compute E = exp - 127 (signed, 9 bits). Classify NaN, Inf, zero/denormal, or normal.
  - ALIGN:
    - E >= 23: magnitude = mant << (E-23), guard=0, sticky=0.
    - 0 <= E < 23: right-shift by 23-E; guard = the first bit shifted out; sticky = OR of the rest.
    - E < 0: magnitude = 0; guard = (E == -1); sticky = OR of all other mantissa bits.
    - E >= OUT_W: flag coarse overflow; skip the shift (no wide shifter beyond OUT_W+1 bits).
    - Denormal nonzero: magnitude=0, guard=0, sticky=1.
  - ROUND: increment decision:
    - toward zero: never.
    - nearest-even: guard && (sticky || lsb).
    - floor: sign && (guard || sticky).
    - ceil: !sign && (guard || sticky).
    - Magnitude is OUT_W+1 bits wide to catch the carry-out.
  - DONE: apply sign, range check and saturation; register c_o and the flags; assert valid_o. Hold everything stable until ready_i=1. Then deassert valid_o and return to IDLE (ready_o=1 on the next cycle).
- Latency and throughput:
  - Operand accepted on edge N → valid_o=1 after edge N+4, assuming en_i held high.
  - ready_o=0 from the acceptance edge until return to IDLE. Throughput is at most one result per 5 cycles.
- Range limits:
  - Signed: max = 2^(OUT_W-1)-1, min = -2^(OUT_W-1); the exact min value is valid, with no flag.
  - Unsigned: max = 2^OUT_W-1, min = 0.
  - A negative value that rounds to 0 gives c_o=0 with no inv. A negative value that rounds nonzero gives c_o=0 with inv_o=1.
- Special cases:
  - NaN → c_o=max, inv_o=1.
  - +Inf → max, inv_o=1.
  - -Inf → min, inv_o=1.
  - Finite out-of-range → saturate to max or min by sign, inv_o=1, nx_o=0.
  - ±0 → c_o=0, no flags.
- Stall: en_i=0 in any state freezes the FSM and outputs. A handshake is taken only in cycles with en_i=1.

Decomposition:
- Package fp_int_pkg holds:
  - FP32 field positions: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MANT_W=23.
  - BIAS=127.
  - Rounding-mode localparams: RND_RTZ, RND_RNE, RND_RDN, RND_RUP.
  - FSM state encoding: IDLE, UNPACK, ALIGN, ROUND, DONE.
- One sub-module, fp_int_yuvarla: combinational round-increment decision from sign, lsb, guard, sticky and mode.

Test Plan:
1. Basic conversion: OUT_W=32 signed, 0x41200000 (10.0), RTZ → c_o=10, inv_o=0, nx_o=0, valid_o exactly 4 cycles after acceptance.
2. Positive rounding:
   - 0x40200000 (2.5): RNE → 2, nx_o=1; RUP → 3.
   - 0x40600000 (3.5): RNE → 4.
   - 0x3F000000 (0.5): RNE → 0, nx_o=1.
3. Negative rounding: 0xC0200000 (-2.5): RDN → 0xFFFFFFFD (-3), RTZ → 0xFFFFFFFE (-2), nx_o=1 in both.
4. Saturation at OUT_W=8 signed:
   - 0x43000000 (128.0) → 0x7F, inv_o=1.
   - 0xC3000000 (-128.0) → 0x80, no flags.
   - 0x7FC00000 (NaN) → 0x7F, inv_o=1.
   - 0xFF800000 (-Inf) → 0x80, inv_o=1.
5. Unsigned at OUT_W=16:
   - 0xBF800000 (-1.0) → 0, inv_o=1.
   - 0xBE800000 (-0.25), RTZ → 0, inv_o=0, nx_o=1.
   - 0x477FFF00 (65535.0) → 0xFFFF, no flags.
6. Handshake and control:
   - ready_i low for 3 cycles: c_o and valid_o stay stable, ready_o=0.
   - en_i low for 2 cycles in ALIGN: result is delayed exactly 2 cycles.
   - rst_i asserted in ROUND: next cycle valid_o=0, ready_o=1, c_o=0.

Source files
------------

// File: rtl/fp_int_cevirici_pkg.sv
// Shared constants for the binary32-to-integer converter: FP32 field layout,
// rounding-mode codes, FSM states and operand classes.
package fp_int_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;
    localparam int BIAS     = 127;

    localparam logic [1:0] RND_RTZ = 2'b00;
    localparam logic [1:0] RND_RNE = 2'b01;
    localparam logic [1:0] RND_RDN = 2'b10;
    localparam logic [1:0] RND_RUP = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ROUND,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_DEN,
        CLS_INF,
        CLS_NAN
    } cls_t;

endpackage

// File: rtl/fp_int_cevirici_yuvarla.sv
// Round-increment decision: says whether the truncated magnitude must be bumped
// by one, given the sign, its lsb, the guard/sticky bits and the rounding mode.
module fp_int_yuvarla
    import fp_int_pkg::*;
(
    input  logic       i_sign,
    input  logic       i_lsb,
    input  logic       i_guard,
    input  logic       i_sticky,
    input  logic [1:0] i_mode,
    output logic       o_inc
);

    always_comb begin
        o_inc = 1'b0;
        case (i_mode)
            RND_RTZ: o_inc = 1'b0;
            RND_RNE: o_inc = i_guard && (i_sticky || i_lsb);
            RND_RDN: o_inc = i_sign && (i_guard || i_sticky);
            RND_RUP: o_inc = !i_sign && (i_guard || i_sticky);
            default: o_inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_int_cevirici.sv
// Multi-cycle binary32 to OUT_W-bit integer converter with runtime rounding mode,
// saturation and invalid/inexact flags; one operation in flight, valid/ready both sides.
module fp_int_cevirici
    import fp_int_pkg::*;
#(
    parameter int OUT_W      = 32,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      g1_i,
    input  logic [1:0]       rnd_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] c_o,
    output logic             inv_o,
    output logic             nx_o
);

    localparam int MW = (OUT_W + 1 > MANT_W + 1) ? OUT_W + 1 : MANT_W + 1;
    localparam logic signed [8:0] E_OUT_W = 9'(OUT_W);
    localparam logic signed [8:0] E_BIAS  = 9'(BIAS);
    localparam logic [OUT_W-1:0] MAX_C = SIGNED_OUT ? {1'b0, {(OUT_W-1){1'b1}}} : {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0] MIN_C = SIGNED_OUT ? {1'b1, {(OUT_W-1){1'b0}}} : {OUT_W{1'b0}};
    localparam logic [OUT_W:0]   POS_LIM = {1'b0, MAX_C};
    localparam logic [OUT_W:0]   NEG_LIM = (OUT_W+1)'(1) << (OUT_W - 1);

    state_t r_state, w_next;

    logic [31:0]             r_g1_p0;
    logic [1:0]              r_rnd_p0;
    logic                    r_sign_p1;
    logic signed [8:0]       r_exp_p1;
    logic [MANT_W:0]         r_mant_p1;
    cls_t                    r_cls_p1;
    logic [OUT_W:0]          r_mag_p2;
    logic                    r_grd_p2, r_stk_p2, r_ovf_p2;
    logic [OUT_W:0]          r_mag_p3;
    logic                    r_nx_p3;
    logic [OUT_W-1:0]        r_c;
    logic                    r_inv, r_nx, r_valid;

    logic [7:0]              w_exp_raw;
    logic [MANT_W-1:0]       w_frac;
    logic [4:0]              w_lsh, w_rsh;
    logic                    w_inc;

    assign w_exp_raw = r_g1_p0[EXP_MSB:EXP_LSB];
    assign w_frac    = r_g1_p0[MANT_W-1:0];
    assign w_lsh     = r_exp_p1[4:0] - 5'd23;
    assign w_rsh     = 5'd23 - r_exp_p1[4:0];

    fp_int_yuvarla u_yuvarla (
        .i_sign   (r_sign_p1),
        .i_lsb    (r_mag_p2[0]),
        .i_guard  (r_grd_p2),
        .i_sticky (r_stk_p2),
        .i_mode   (r_rnd_p0),
        .o_inc    (w_inc)
    );

    // Packs {result, inv, nx}; negative values are negated here, after rounding on the magnitude.
    function automatic logic [OUT_W+1:0] saturate(input cls_t cls, input logic sgn, input logic ovf,
                                                 input logic [OUT_W:0] mag, input logic inexact);
        logic [OUT_W-1:0] c;
        logic             inv;
        logic             x;
        c   = '0;
        inv = 1'b1;
        x   = 1'b0;
        if (cls == CLS_NAN) begin
            c = MAX_C;
        end else if (cls == CLS_INF || ovf) begin
            c = sgn ? MIN_C : MAX_C;
        end else if (!sgn) begin
            if (mag > POS_LIM) begin
                c = MAX_C;
            end else begin
                c   = mag[OUT_W-1:0];
                inv = 1'b0;
                x   = inexact;
            end
        end else if (SIGNED_OUT) begin
            if (mag > NEG_LIM) begin
                c = MIN_C;
            end else begin
                c   = -mag[OUT_W-1:0];
                inv = 1'b0;
                x   = inexact;
            end
        end else if (mag == '0) begin
            inv = 1'b0;
            x   = inexact;
        end else begin
            c = MIN_C;
        end
        return {c, inv, x};
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else if (en_i) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (valid_i) w_next = UNPACK;
            UNPACK:  w_next = ALIGN;
            ALIGN:   w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    if (r_valid && ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (r_state == IDLE);
        valid_o = r_valid;
        c_o     = r_c;
        inv_o   = r_inv;
        nx_o    = r_nx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_g1_p0   <= '0;
            r_rnd_p0  <= '0;
            r_sign_p1 <= 1'b0;
            r_exp_p1  <= '0;
            r_mant_p1 <= '0;
            r_cls_p1  <= CLS_ZERO;
            r_mag_p2  <= '0;
            r_grd_p2  <= 1'b0;
            r_stk_p2  <= 1'b0;
            r_ovf_p2  <= 1'b0;
            r_mag_p3  <= '0;
            r_nx_p3   <= 1'b0;
            r_c       <= '0;
            r_inv     <= 1'b0;
            r_nx      <= 1'b0;
            r_valid   <= 1'b0;
        end else if (en_i) begin
            case (r_state)
                // p0: operand capture
                IDLE: begin
                    if (valid_i) begin
                        r_g1_p0  <= g1_i;
                        r_rnd_p0 <= rnd_i;
                    end
                end
                // p1: field split and classification
                UNPACK: begin
                    r_sign_p1 <= r_g1_p0[SIGN_BIT];
                    r_exp_p1  <= $signed({1'b0, w_exp_raw}) - E_BIAS;
                    r_mant_p1 <= (w_exp_raw == 8'd0) ? '0 : {1'b1, w_frac};
                    if (w_exp_raw == 8'hFF)
                        r_cls_p1 <= (w_frac != '0) ? CLS_NAN : CLS_INF;
                    else if (w_exp_raw == 8'd0)
                        r_cls_p1 <= (w_frac != '0) ? CLS_DEN : CLS_ZERO;
                    else
                        r_cls_p1 <= CLS_NORM;
                end
                // p2: alignment to the integer point, guard/sticky extraction
                ALIGN: begin
                    r_mag_p2 <= '0;
                    r_grd_p2 <= 1'b0;
                    r_stk_p2 <= 1'b0;
                    r_ovf_p2 <= 1'b0;
                    if (r_cls_p1 == CLS_DEN) begin
                        r_stk_p2 <= 1'b1;
                    end else if (r_cls_p1 == CLS_NORM) begin
                        if (r_exp_p1 >= E_OUT_W) begin
                            r_ovf_p2 <= 1'b1;
                        end else if (r_exp_p1 >= 9'sd23) begin
                            r_mag_p2 <= (OUT_W+1)'(MW'(r_mant_p1) << w_lsh);
                        end else if (r_exp_p1 >= 9'sd0) begin
                            r_mag_p2 <= (OUT_W+1)'(r_mant_p1 >> w_rsh);
                            r_grd_p2 <= r_mant_p1[w_rsh - 5'd1];
                            r_stk_p2 <= |(r_mant_p1 & ((24'd1 << (w_rsh - 5'd1)) - 24'd1));
                        end else begin
                            r_grd_p2 <= (r_exp_p1 == -9'sd1);
                            r_stk_p2 <= (r_exp_p1 == -9'sd1) ? |r_mant_p1[MANT_W-1:0] : 1'b1;
                        end
                    end
                end
                // p3: rounding increment, carry lands in the extra top bit
                ROUND: begin
                    r_mag_p3 <= r_mag_p2 + (OUT_W+1)'(w_inc);
                    r_nx_p3  <= r_grd_p2 | r_stk_p2;
                end
                // p4: sign, range check, result hold until consumed
                DONE: begin
                    if (!r_valid) begin
                        {r_c, r_inv, r_nx} <= saturate(r_cls_p1, r_sign_p1, r_ovf_p2, r_mag_p3, r_nx_p3);
                        r_valid <= 1'b1;
                    end else if (ready_i) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_int_cevirici.sv
// Scoreboard bench: three converter configurations driven in lockstep, each checked
// against an exact-arithmetic rounding model.
module tb_fp_int_cevirici;

    typedef struct packed {
        logic [31:0] g;
        logic [1:0]  m;
        logic [31:0] c;
        logic        inv;
        logic        nx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i, en_i, valid_i, ready_i;
    logic [31:0] g1_i;
    logic [1:0]  rnd_i;

    logic        rdy_a, rdy_b, rdy_c;
    logic        vo_a, vo_b, vo_c;
    logic        inv_a, inv_b, inv_c;
    logic        nx_a, nx_b, nx_c;
    logic [31:0] c_a;
    logic [7:0]  c_b;
    logic [15:0] c_c;

    exp_t qa[$], qb[$], qc[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   rand_ctl = 1'b0;
    logic        hold_prev[3];
    logic [33:0] snap[3];

    always #5 clk = ~clk;

    fp_int_cevirici #(.OUT_W(32), .SIGNED_OUT(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .valid_i(valid_i), .ready_o(rdy_a),
        .g1_i(g1_i), .rnd_i(rnd_i), .valid_o(vo_a), .ready_i(ready_i),
        .c_o(c_a), .inv_o(inv_a), .nx_o(nx_a));

    fp_int_cevirici #(.OUT_W(8), .SIGNED_OUT(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .valid_i(valid_i), .ready_o(rdy_b),
        .g1_i(g1_i), .rnd_i(rnd_i), .valid_o(vo_b), .ready_i(ready_i),
        .c_o(c_b), .inv_o(inv_b), .nx_o(nx_b));

    fp_int_cevirici #(.OUT_W(16), .SIGNED_OUT(1'b0)) dut_c (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .valid_i(valid_i), .ready_o(rdy_c),
        .g1_i(g1_i), .rnd_i(rnd_i), .valid_o(vo_c), .ready_i(ready_i),
        .c_o(c_c), .inv_o(inv_c), .nx_o(nx_c));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    endtask

    // Exact value = mant * 2^sc; round the real number, then range-check the signed result.
    function automatic exp_t model(input logic [31:0] g, input logic [1:0] m, input int ow, input bit sgn);
        exp_t   e;
        longint mx, mn, mant, ip, r, half, mag, v;
        int     sc, sh;
        logic   s, up, gt, eq, inx;
        e.g = g; e.m = m;
        mx = sgn ? (64'sd1 <<< (ow - 1)) - 1 : (64'sd1 <<< ow) - 1;
        mn = sgn ? -(64'sd1 <<< (ow - 1)) : 64'sd0;
        s  = g[31];
        if (g[30:23] == 8'hFF) begin
            v = (g[22:0] != 23'd0) ? mx : (s ? mn : mx);
            e.inv = 1'b1; e.nx = 1'b0;
        end else begin
            mant = (g[30:23] == 8'd0) ? longint'(g[22:0]) : longint'({1'b1, g[22:0]});
            sc   = (g[30:23] == 8'd0) ? -149 : int'(g[30:23]) - 150;
            gt = 1'b0; eq = 1'b0; inx = 1'b0;
            if (sc >= 0) begin
                ip = (sc > 30) ? (64'sd1 <<< 40) : (mant <<< sc);
            end else begin
                sh = -sc;
                if (sh > 40) begin
                    ip  = 0;
                    inx = (mant != 0);
                end else begin
                    ip   = mant >>> sh;
                    r    = mant - (ip <<< sh);
                    half = 64'sd1 <<< (sh - 1);
                    gt   = (r > half);
                    eq   = (r == half);
                    inx  = (r != 0);
                end
            end
            case (m)
                2'd0:    up = 1'b0;
                2'd1:    up = gt || (eq && ip[0]);
                2'd2:    up = s && inx;
                default: up = !s && inx;
            endcase
            mag = ip + longint'(up);
            v   = s ? -mag : mag;
            if (v > mx) begin
                v = mx; e.inv = 1'b1; e.nx = 1'b0;
            end else if (v < mn) begin
                v = mn; e.inv = 1'b1; e.nx = 1'b0;
            end else begin
                e.inv = 1'b0; e.nx = inx;
            end
        end
        e.c = 32'(v & ((64'sd1 <<< ow) - 1));
        return e;
    endfunction

    task automatic mon(input int i, input logic vo, input logic [31:0] c, input logic inv,
                       input logic nx, input logic rdy);
        exp_t e;
        logic fire, have;
        if (vo && hold_prev[i]) check($sformatf("hold_stable%0d", i), {c, inv, nx}, snap[i]);
        if (vo) check($sformatf("ready_low_while_valid%0d", i), rdy, 1'b0);
        fire = vo && ready_i && en_i;
        if (fire) begin
            have = 1'b0;
            e    = '0;
            case (i)
                0: if (qa.size() > 0) begin have = 1'b1; e = qa.pop_front(); end
                1: if (qb.size() > 0) begin have = 1'b1; e = qb.pop_front(); end
                default: if (qc.size() > 0) begin have = 1'b1; e = qc.pop_front(); end
            endcase
            if (!have) check($sformatf("unexpected_out%0d", i), 1'b1, 1'b0);
            else check($sformatf("out%0d g=%h rnd=%0d {c,inv,nx}", i, e.g, e.m),
                       {c, inv, nx}, {e.c, e.inv, e.nx});
        end
        hold_prev[i] = vo && !fire;
        snap[i]      = {c, inv, nx};
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            mon(0, vo_a, c_a, inv_a, nx_a, rdy_a);
            mon(1, vo_b, 32'(c_b), inv_b, nx_b, rdy_b);
            mon(2, vo_c, 32'(c_c), inv_c, nx_c, rdy_c);
        end
    end

    task automatic tick();
        if (rand_ctl) begin
            en_i    = ($urandom % 4) != 0;
            ready_i = ($urandom % 3) != 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] g, input logic [1:0] m);
        logic acc;
        int   n;
        valid_i = 1'b1; g1_i = g; rnd_i = m;
        acc = 1'b0; n = 0;
        while (!acc && n < 300) begin
            if (rand_ctl) begin
                en_i    = ($urandom % 4) != 0;
                ready_i = ($urandom % 3) != 0;
            end
            acc = en_i && rdy_a;
            if (acc) begin
                qa.push_back(model(g, m, 32, 1'b1));
                qb.push_back(model(g, m, 8, 1'b1));
                qc.push_back(model(g, m, 16, 1'b0));
            end
            @(posedge clk);
            #1;
            n++;
        end
        valid_i = 1'b0;
        g1_i    = $urandom;
        if (!acc) check("send_timeout", 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] g;
        int          k;
        k = $urandom_range(15, 0);
        g = $urandom;
        case (k)
            0: g[30:23] = 8'hFF;
            1: begin g[30:23] = 8'hFF; g[22:0] = 23'd0; end
            2: g[30:23] = 8'd0;
            3: g[30:0] = 31'd0;
            default: begin
                g[30:23] = 8'($urandom_range(160, 100));
                if (k < 9) g[15:0] = 16'd0;
            end
        endcase
        return g;
    endfunction

    logic [33:0] dir_tab [14];
    int          lat;

    initial begin
        dir_tab = '{
            {32'h41200000, 2'd0}, {32'h40200000, 2'd1}, {32'h40200000, 2'd3},
            {32'h40600000, 2'd1}, {32'h3F000000, 2'd1}, {32'hC0200000, 2'd2},
            {32'hC0200000, 2'd0}, {32'h43000000, 2'd0}, {32'hC3000000, 2'd0},
            {32'h7FC00000, 2'd0}, {32'hFF800000, 2'd0}, {32'hBF800000, 2'd0},
            {32'hBE800000, 2'd0}, {32'h477FFF00, 2'd0}};
        for (int i = 0; i < 3; i++) begin hold_prev[i] = 1'b0; snap[i] = '0; end
        rst_i = 1'b1; en_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; g1_i = '0; rnd_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_o", rdy_a, 1'b1);
        check("rst_valid_o", vo_a, 1'b0);
        check("rst_c_o", c_a, 32'd0);
        check("rst_flags", {inv_a, nx_a, inv_b, nx_b}, 4'd0);
        rst_i = 1'b0;
        tick();

        // 10.0 with the consumer stalled: latency, then a 3-cycle hold
        ready_i = 1'b0;
        send(32'h41200000, 2'd0);
        lat = 0;
        while (!vo_a && lat < 20) begin tick(); lat++; end
        check("latency", lat, 4);
        repeat (3) tick();
        check("ready_o_low_in_hold", rdy_a, 1'b0);
        check("valid_o_held", vo_a, 1'b1);
        ready_i = 1'b1;
        tick();

        // clock-enable low for two cycles while in ALIGN
        send(32'h40200000, 2'd1);
        tick();
        lat = 1;
        en_i = 1'b0;
        tick(); tick();
        lat += 2;
        en_i = 1'b1;
        while (!vo_a && lat < 20) begin tick(); lat++; end
        check("latency_with_stall", lat, 6);
        tick();

        // reset while in ROUND drops the operation
        send(32'h41200000, 2'd0);
        tick(); tick();
        rst_i = 1'b1;
        qa.delete(); qb.delete(); qc.delete();
        tick();
        check("midrst_valid_o", {vo_a, vo_b, vo_c}, 3'b000);
        check("midrst_ready_o", {rdy_a, rdy_b, rdy_c}, 3'b111);
        check("midrst_c_o", {c_a, c_b, c_c}, 56'd0);
        rst_i = 1'b0;
        repeat (8) tick();

        for (int i = 0; i < 14; i++) send(dir_tab[i][33:2], dir_tab[i][1:0]);

        rand_ctl = 1'b1;
        for (int i = 0; i < 300; i++) send(rand_op(), 2'($urandom_range(3, 0)));
        rand_ctl = 1'b0;
        en_i = 1'b1; ready_i = 1'b1;
        lat = 0;
        while ((qa.size() + qb.size() + qc.size()) > 0 && lat < 100) begin tick(); lat++; end
        check("drain_pending", qa.size() + qb.size() + qc.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
